// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, id width,
// and a lowest-set-index helper used by the priority encoders.
// Pure definitions; no timing or flow control.
package irq_ctrl_pkg;

  localparam int ID_W    = 3;
  localparam int MAX_SRC = 6;

  localparam logic [2:0] IRQ_PEND  = 3'd0;
  localparam logic [2:0] IRQ_MASK  = 3'd1;
  localparam logic [2:0] IRQ_MODE  = 3'd2;
  localparam logic [2:0] IRQ_CLAIM = 3'd3;
  localparam logic [2:0] IRQ_ISR   = 3'd4;

  // Returns {valid, index} of the lowest set bit; lower index means higher priority.
  function automatic logic [ID_W:0] lowest_set(input logic [MAX_SRC-1:0] v);
    lowest_set = '0;
    for (int k = MAX_SRC - 1; k >= 0; k--) begin
      if (v[k]) lowest_set = {1'b1, ID_W'(k)};
    end
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: N-bit request vector -> {valid, id} of lowest set bit.
// Purely combinational, zero latency.
// No flow control; output follows input.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N = 6
) (
  input  logic [N-1:0]    vec,
  output logic            vld,
  output logic [ID_W-1:0] id
);

  logic [MAX_SRC-1:0] vec_ext;

  // Widen to the helper's fixed width; unused upper bits stay zero.
  always_comb begin
    vec_ext        = '0;
    vec_ext[N-1:0] = vec;
  end

  assign {vld, id} = lowest_set(vec_ext);

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches level/edge requests, masks, prioritises, tracks nesting, drives HWInt.
// hwint is registered: one cycle after PEND/MASK/ISR change; rdata is combinational.
// No backpressure; register reads/writes complete in the cycle they are strobed.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq,
  input  logic [2:0]      addr,
  input  logic            we,
  input  logic            re,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [5:0]      hwint
);

  logic [NSRC-1:0] irq_q,   irq_d;
  logic [NSRC-1:0] pend_q,  pend_d;
  logic [NSRC-1:0] mask_q,  mask_d;
  logic [NSRC-1:0] mode_q,  mode_d;
  logic [NSRC-1:0] isr_q,   isr_d;
  logic [NSRC-1:0] hwint_q, hwint_d;

  logic [NSRC-1:0] elig, thresh, rise, w1c, mode_chg, claim_oh, eoi_oh;
  logic            elig_vld, isr_vld, claim_en, eoi_en;
  logic [ID_W-1:0] elig_id, isr_id, eoi_id;

  // Highest-priority eligible source: the one a claim would hand out.
  irq_prio_enc #(.N(NSRC)) u_enc_elig (
    .vec (elig),
    .vld (elig_vld),
    .id  (elig_id)
  );

  // Highest-priority in-service source: only strictly higher priorities may nest.
  irq_prio_enc #(.N(NSRC)) u_enc_isr (
    .vec (isr_q),
    .vld (isr_vld),
    .id  (isr_id)
  );

  // Eligibility, strobe decode and per-bit side-effect masks.
  always_comb begin
    claim_en = re && !we && (addr == IRQ_CLAIM) && elig_vld;
    eoi_id   = wdata[ID_W-1:0];
    eoi_en   = we && (addr == IRQ_CLAIM) && (int'(eoi_id) < NSRC);
    rise     = irq & ~irq_q;
    w1c      = (we && addr == IRQ_PEND) ? (wdata[NSRC-1:0] & mode_q) : '0;
    mode_chg = (we && addr == IRQ_MODE) ? (wdata[NSRC-1:0] ^ mode_q) : '0;
    thresh   = '0;
    claim_oh = '0;
    eoi_oh   = '0;
    for (int k = 0; k < NSRC; k++) begin
      thresh[k]   = !isr_vld || (ID_W'(k) < isr_id);
      claim_oh[k] = claim_en && (elig_id == ID_W'(k));
      eoi_oh[k]   = eoi_en && (eoi_id == ID_W'(k));
    end
    elig = pend_q & mask_q & thresh;
  end

  // Next-state: level bits track irq; edge bits hold until cleared, a fresh edge beats a clear.
  always_comb begin
    irq_d   = irq;
    pend_d  = (mode_q & ((pend_q & ~w1c & ~claim_oh) | rise)) | (~mode_q & irq);
    pend_d  = pend_d & ~mode_chg;
    mask_d  = (we && addr == IRQ_MASK) ? wdata[NSRC-1:0] : mask_q;
    mode_d  = (we && addr == IRQ_MODE) ? wdata[NSRC-1:0] : mode_q;
    isr_d   = (isr_q | claim_oh) & ~eoi_oh;
    hwint_d = elig;
  end

  // State registers; reset drops all pending and in-service state.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      isr_q   <= '0;
      hwint_q <= '0;
    end else begin
      irq_q   <= irq_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      isr_q   <= isr_d;
      hwint_q <= hwint_d;
    end
  end

  // Register read mux, zero-extended; CLAIM shows what a claim would return now.
  always_comb begin
    rdata = '0;
    case (addr)
      IRQ_PEND:  rdata = 32'(pend_q);
      IRQ_MASK:  rdata = 32'(mask_q);
      IRQ_MODE:  rdata = 32'(mode_q);
      IRQ_CLAIM: rdata = elig_vld ? {1'b1, 28'b0, elig_id} : 32'b0;
      IRQ_ISR:   rdata = 32'(isr_q);
      default:   rdata = '0;
    endcase
  end

  // Unused HWInt lines stay low.
  always_comb begin
    hwint            = '0;
    hwint[NSRC-1:0]  = hwint_q;
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: directed scenarios then random traffic vs a reference model.
// Expected rdata/hwint per cycle go into a queue; a monitor compares mid-cycle.
// Inputs change 1 time unit after the rising edge.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int N = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [N-1:0] irq;
  logic [2:0]  addr;
  logic        we, re;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [5:0]  hwint;

  irq_ctrl #(.NSRC(N)) dut (
    .clk   (clk),
    .reset (reset),
    .irq   (irq),
    .addr  (addr),
    .we    (we),
    .re    (re),
    .wdata (wdata),
    .rdata (rdata),
    .hwint (hwint)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd;
    logic [5:0]  hw;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state, one bit per source.
  logic [N-1:0] m_pend, m_mask, m_mode, m_isr, m_prev, m_hw;
  logic [N-1:0] cur_irq;

  function automatic int first_isr();
    for (int k = 0; k < N; k++) if (m_isr[k]) return k;
    return N;
  endfunction

  function automatic bit is_elig(int k);
    return m_pend[k] && m_mask[k] && (k < first_isr());
  endfunction

  function automatic int claim_pick();
    for (int k = 0; k < N; k++) if (is_elig(k)) return k;
    return -1;
  endfunction

  function automatic logic [31:0] exp_rdata(logic [2:0] a);
    int p;
    case (a)
      3'd0: return 32'(m_pend);
      3'd1: return 32'(m_mask);
      3'd2: return 32'(m_mode);
      3'd3: begin
        p = claim_pick();
        if (p < 0) return 32'h0;
        return 32'h8000_0000 + 32'(p);
      end
      3'd4: return 32'(m_isr);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(logic rst, logic [N-1:0] i, logic [2:0] a, logic w, logic r,
                            logic [31:0] d);
    logic [N-1:0] np, nh;
    int pick, eoi;
    if (rst) begin
      m_pend = '0; m_mask = '0; m_mode = '0; m_isr = '0; m_prev = '0; m_hw = '0;
      return;
    end
    pick = claim_pick();
    for (int k = 0; k < N; k++) begin
      nh[k] = is_elig(k);
      if (!m_mode[k]) begin
        np[k] = i[k];
      end else begin
        np[k] = m_pend[k];
        if (w && a == 3'd0 && d[k]) np[k] = 1'b0;
        if (r && !w && a == 3'd3 && pick == k) np[k] = 1'b0;
        if (i[k] && !m_prev[k]) np[k] = 1'b1;
      end
    end
    if (w && a == 3'd2) begin
      for (int k = 0; k < N; k++) if (d[k] != m_mode[k]) np[k] = 1'b0;
      m_mode = d[N-1:0];
    end
    if (w && a == 3'd1) m_mask = d[N-1:0];
    if (r && !w && a == 3'd3 && pick >= 0) m_isr[pick] = 1'b1;
    if (w && a == 3'd3) begin
      eoi = int'(d[2:0]);
      if (eoi < N) m_isr[eoi] = 1'b0;
    end
    m_pend = np;
    m_prev = i;
    m_hw   = nh;
  endtask

  // One bus cycle: drive, record expectation from current model state, advance model.
  task automatic cyc(logic rst, logic [N-1:0] i, logic [2:0] a, logic w, logic r,
                     logic [31:0] d);
    exp_t e;
    reset = rst; irq = i; addr = a; we = w; re = r; wdata = d;
    e.rd = exp_rdata(a);
    e.hw = 6'(m_hw);
    exp_q.push_back(e);
    @(posedge clk);
    model_step(rst, i, a, w, r, d);
    #1;
  endtask

  task automatic idle();               cyc(1'b0, cur_irq, 3'd5, 1'b0, 1'b0, 32'h0); endtask
  task automatic wr(logic [2:0] a, logic [31:0] d); cyc(1'b0, cur_irq, a, 1'b1, 1'b0, d); endtask
  task automatic rd(logic [2:0] a);    cyc(1'b0, cur_irq, a, 1'b0, 1'b1, 32'h0); endtask
  task automatic pulse(int k);
    cur_irq[k] = 1'b1; idle(); cur_irq[k] = 1'b0; idle();
  endtask

  // Monitor: compare DUT outputs against queued expectations mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (rdata !== e.rd) begin
          n_fail++;
          $display("FAIL rdata addr=%0d t=%0t: got %h expected %h", addr, $time, rdata, e.rd);
        end
        n_tests++;
        if (hwint !== e.hw) begin
          n_fail++;
          $display("FAIL hwint t=%0t: got %h expected %h", $time, hwint, e.hw);
        end
      end
    end
  end

  initial begin
    int op;
    logic [2:0] ra;
    cur_irq = '0;
    m_pend = '0; m_mask = '0; m_mode = '0; m_isr = '0; m_prev = '0; m_hw = '0;
    reset = 1'b1; irq = '0; addr = '0; we = 1'b0; re = 1'b0; wdata = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Reset state readback.
    for (int a = 0; a < 8; a++) cyc(1'b1, '0, 3'(a), 1'b0, 1'b0, 32'h0);

    // Edge, single source.
    wr(3'd2, 32'h3F); wr(3'd1, 32'h3F);
    pulse(2); rd(3'd0); rd(3'd3); rd(3'd0); rd(3'd4); idle();

    // Nesting.
    pulse(4); idle(); rd(3'd0);
    pulse(0); idle(); rd(3'd3); rd(3'd4);
    wr(3'd3, 32'd0); idle(); idle();
    wr(3'd3, 32'd2); idle(); idle(); rd(3'd4);

    // Level.
    wr(3'd2, 32'h0); wr(3'd1, 32'h02);
    cur_irq = 6'h02; idle(); idle(); rd(3'd0);
    wr(3'd0, 32'h02); rd(3'd0); rd(3'd3); rd(3'd4); rd(3'd0);
    cur_irq = '0; idle(); wr(3'd3, 32'd1); idle(); rd(3'd0); rd(3'd4);

    // Collisions: fresh edge vs W1C, then mode toggle clears.
    wr(3'd2, 32'h3F); wr(3'd1, 32'h3F);
    cur_irq = 6'h08; wr(3'd0, 32'h08); cur_irq = '0; rd(3'd0);
    wr(3'd2, 32'h37); rd(3'd0); rd(3'd2);

    // Empty / masked claim, out-of-range EOI.
    wr(3'd2, 32'h3F); wr(3'd1, 32'h0);
    pulse(5); rd(3'd0); rd(3'd3); rd(3'd4); wr(3'd3, 32'd7); rd(3'd4);

    // Reset while nested with pending work.
    wr(3'd1, 32'h3F);
    pulse(2); rd(3'd3); pulse(0); rd(3'd3);
    cur_irq = 6'h12; idle(); cur_irq = '0; idle(); idle();
    rd(3'd0); rd(3'd4);
    cyc(1'b1, '0, 3'd0, 1'b0, 1'b0, 32'h0);
    rd(3'd0); rd(3'd4); rd(3'd1); rd(3'd2); idle();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) cur_irq = 6'($urandom);
      op = $urandom_range(0, 9);
      ra = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        cyc(1'b1, cur_irq, ra, 1'b0, 1'b0, 32'h0);
      end else begin
        case (op)
          0, 1, 2: idle();
          3:       rd(ra);
          4:       wr(ra, $urandom);
          5, 6:    rd(3'd3);
          7:       wr(3'd3, 32'($urandom_range(0, 7)));
          8:       wr(3'($urandom_range(0, 2)), 32'($urandom_range(0, 63)));
          default: cyc(1'b0, cur_irq, ra, 1'b1, 1'b1, $urandom);
        endcase
      end
    end

    idle(); idle();
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
